// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Covers the FSM encoding, the abort read data and the word-align mask.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;
  localparam logic [63:0] WORD_MASK  = ~64'h3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU fetch/data and memory-side bundle of the memory port arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;
  logic              busy;
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  m_ack, m_rdata,
    output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, busy, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output m_ack, m_rdata,
    input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, busy, err
  );
endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while a fetch was pending.
// at_max tells the arbiter the fetch side must win the next grant.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic start,
  input  logic inc,
  input  logic clr,
  input  logic pend,
  output logic at_max
);
  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      r_cnt <= '0;
    end else if (clr || (inc && !pend)) begin
      r_cnt <= '0;
    end else if (inc && !at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_max = (r_cnt == CW'(STARVE_MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of a single-port memory, one access in flight.
// Define ARB_TIMEOUT_EN to abort accesses whose m_ack never arrives.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 16
`endif
) (
  input  logic clock,
  input  logic start,
  mem_port_arbiter_if.slave bus
);
  arb_state_e        r_state;
  arb_state_e        w_next;
  logic              w_at_max;
  logic              w_win_i;
  logic              w_win_d;
  logic              w_gnt_i;
  logic              w_gnt_d;
  logic              w_busy;
  logic              w_done;
  logic              w_tmo;
  logic [DATA_W-1:0] w_rd;
  logic              r_i_gnt;
  logic              r_d_gnt;
  logic              r_i_valid;
  logic              r_d_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  assign w_busy  = (r_state != IDLE);
  assign w_win_d = bus.d_req && !(bus.i_req && w_at_max);
  assign w_win_i = bus.i_req && !w_win_d;
  assign w_gnt_d = !w_busy && w_win_d;
  assign w_gnt_i = !w_busy && w_win_i;
  assign w_done  = w_busy && (bus.m_ack || w_tmo);
  assign w_rd    = bus.m_ack ? bus.m_rdata : DATA_W'(ABORT_DATA);

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clock (clock),
    .start (start),
    .inc   (w_gnt_d),
    .clr   (w_gnt_i),
    .pend  (bus.i_req),
    .at_max(w_at_max)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo;
  logic          r_err;

  // r_tmo is the number of busy edges already seen since the grant edge
  assign w_tmo = w_busy && !bus.m_ack && (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= w_busy ? r_tmo + 1'b1 : '0;
      r_err <= w_tmo;
    end
  end

  assign bus.err = r_err;
`else
  assign w_tmo   = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clock or negedge start) begin
    if (!start) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        unique case (1'b1)
          w_win_d: w_next = BUSY_D;
          w_win_i: w_next = BUSY_I;
          default: w_next = IDLE;
        endcase
      end
      default: if (w_done) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      r_i_gnt   <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_gnt   <= w_gnt_i;
      r_d_gnt   <= w_gnt_d;
      r_i_valid <= w_done && (r_state == BUSY_I);
      r_d_valid <= w_done && (r_state == BUSY_D);
      if (w_gnt_i || w_gnt_d) begin
        r_addr  <= (w_gnt_d ? bus.d_addr : bus.i_addr)
                   & WORD_MASK[ADDR_W-1:0];
        r_we    <= w_gnt_d && bus.d_we;
        r_wdata <= w_gnt_d ? bus.d_wdata : '0;
      end
      if (w_done && (r_state == BUSY_I))
        r_i_rdata <= w_rd;
      // a completed store leaves the load data alone
      if (w_done && (r_state == BUSY_D) && !(r_we && bus.m_ack))
        r_d_rdata <= w_rd;
    end
  end

  assign bus.i_gnt   = r_i_gnt;
  assign bus.i_valid = r_i_valid;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_gnt   = r_d_gnt;
  assign bus.d_valid = r_d_valid;
  assign bus.d_rdata = r_d_rdata;
  assign bus.m_req   = w_busy;
  assign bus.busy    = w_busy;
  assign bus.m_we    = w_busy && r_we;
  assign bus.m_addr  = r_addr;
  assign bus.m_wdata = r_wdata;
endmodule
